adder_arbiter: RTL and testbench

Shares the execute-stage 32-bit adder between two requesters: requester 0 is the ALU issue path and requester 1 is the load/store address generator. The block grants one requester per cycle with round-robin priority and drives the granted operands and FUNCT_SEVEN onto the combinational adder. It captures the adder result and flags into an output register and holds them under a valid/ready handshake until the consumer accepts. Sustained throughput is one operation per cycle, with one cycle of latency.

---
 rtl/adder_arbiter.sv | 124 ++++++++++++
 tb/tb_adder_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing the execute-stage adder between the ALU
// issue path and the load/store address generator, with a registered result slot.
module adder_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  input  logic [6:0]       i_req0_funct_seven,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  input  logic [6:0]       i_req1_funct_seven,
  output logic [WIDTH-1:0] o_add_a,
  output logic [WIDTH-1:0] o_add_b,
  output logic [6:0]       o_add_funct_seven,
  input  logic [WIDTH-1:0] i_add_y,
  input  logic             i_add_c,
  input  logic             i_add_v,
  input  logic             i_add_n,
  input  logic             i_add_z,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic             o_res_id,
  output logic [WIDTH-1:0] o_res_y,
  output logic             o_res_c,
  output logic             o_res_v,
  output logic             o_res_n,
  output logic             o_res_z
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_prio;
  logic             r_res_id;
  logic [WIDTH-1:0] r_res_y;
  logic             r_res_c;
  logic             r_res_v;
  logic             r_res_n;
  logic             r_res_z;
  logic             w_free;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_gnt;

  always_comb begin
    w_free            = (r_state == S_EMPTY) || i_res_ready;
    w_gnt0            = 1'b0;
    w_gnt1            = 1'b0;
    o_add_a           = '0;
    o_add_b           = '0;
    o_add_funct_seven = '0;
    w_state_nxt       = r_state;
    if (!i_rst && w_free) begin
      // r_prio==1 prefers requester 1 when both are valid
      if (i_req0_valid && (!i_req1_valid || !r_prio))
        w_gnt0 = 1'b1;
      else if (i_req1_valid)
        w_gnt1 = 1'b1;
    end
    w_gnt = w_gnt0 || w_gnt1;
    unique case (1'b1)
      w_gnt0: begin
        o_add_a           = i_req0_a;
        o_add_b           = i_req0_b;
        o_add_funct_seven = i_req0_funct_seven;
      end
      w_gnt1: begin
        o_add_a           = i_req1_a;
        o_add_b           = i_req1_b;
        o_add_funct_seven = i_req1_funct_seven;
      end
      default: ;
    endcase
    if (w_gnt)
      w_state_nxt = S_FULL;
    else if (i_res_ready)
      w_state_nxt = S_EMPTY;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_EMPTY;
      r_prio   <= 1'b0;
      r_res_id <= 1'b0;
      r_res_y  <= '0;
      r_res_c  <= 1'b0;
      r_res_v  <= 1'b0;
      r_res_n  <= 1'b0;
      r_res_z  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt) begin
        r_res_id <= w_gnt1;
        r_res_y  <= i_add_y;
        r_res_c  <= i_add_c;
        r_res_v  <= i_add_v;
        r_res_n  <= i_add_n;
        r_res_z  <= i_add_z;
        r_prio   <= w_gnt0;
      end
    end
  end

  assign o_req0_ready = w_gnt0;
  assign o_req1_ready = w_gnt1;
  assign o_res_valid  = (r_state == S_FULL);
  assign o_res_id     = r_res_id;
  assign o_res_y      = r_res_y;
  assign o_res_c      = r_res_c;
  assign o_res_v      = r_res_v;
  assign o_res_n      = r_res_n;
  assign o_res_z      = r_res_z;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: vector table plus random traffic,
// with a reference adder and a result scoreboard.
module tb_adder_arbiter;

  localparam logic [6:0] ADD = 7'b0000000;
  localparam logic [6:0] SUB = 7'b0100000;

  typedef struct {
    logic        rst;
    logic        v0;
    logic        v1;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [6:0]  f0;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [6:0]  f1;
    logic        rr;
    logic        r0;
    logic        r1;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] y;
    logic        c;
    logic        v;
    logic        n;
    logic        z;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [6:0]  req0_f, req1_f;
  logic [31:0] add_a, add_b, add_y;
  logic [6:0]  add_f;
  logic        add_c, add_v, add_n, add_z;
  logic        res_valid, res_ready, res_id;
  logic [31:0] res_y;
  logic        res_c, res_v, res_n, res_z;

  int   checks = 0;
  int   errors = 0;
  res_t sb[$];
  res_t last;
  logic exp_valid;
  logic exp_prio;
  vec_t tbl[$];

  always #5 clk = ~clk;

  adder_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
    .i_req0_a(req0_a), .i_req0_b(req0_b),
    .i_req0_funct_seven(req0_f),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
    .i_req1_a(req1_a), .i_req1_b(req1_b),
    .i_req1_funct_seven(req1_f),
    .o_add_a(add_a), .o_add_b(add_b),
    .o_add_funct_seven(add_f),
    .i_add_y(add_y), .i_add_c(add_c), .i_add_v(add_v),
    .i_add_n(add_n), .i_add_z(add_z),
    .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_res_id(res_id), .o_res_y(res_y),
    .o_res_c(res_c), .o_res_v(res_v),
    .o_res_n(res_n), .o_res_z(res_z)
  );

  function automatic res_t ref_add(logic id, logic [31:0] a,
                                   logic [31:0] b, logic [6:0] f);
    res_t        r;
    logic [31:0] bb;
    logic [32:0] s;
    bb   = (f == SUB) ? ~b : b;
    s    = {1'b0, a} + {1'b0, bb} + ((f == SUB) ? 33'd1 : 33'd0);
    r.id = id;
    r.y  = s[31:0];
    r.c  = s[32];
    r.v  = (a[31] == bb[31]) && (r.y[31] != a[31]);
    r.n  = r.y[31];
    r.z  = (r.y == 32'd0);
    return r;
  endfunction

  // Environment adder driven by the DUT's shared-adder outputs
  res_t env;
  always_comb begin
    env   = ref_add(1'b0, add_a, add_b, add_f);
    add_y = env.y;
    add_c = env.c;
    add_v = env.v;
    add_n = env.n;
    add_z = env.z;
  end

  function automatic vec_t mk(logic r, logic v0, logic v1,
      logic [31:0] a0, logic [31:0] b0, logic [6:0] f0,
      logic [31:0] a1, logic [31:0] b1, logic [6:0] f1,
      logic rr, logic r0, logic r1);
    vec_t t;
    t.rst = r;  t.v0 = v0; t.v1 = v1;
    t.a0 = a0;  t.b0 = b0; t.f0 = f0;
    t.a1 = a1;  t.b1 = b1; t.f1 = f1;
    t.rr = rr;  t.r0 = r0; t.r1 = r1;
    return t;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at negedge; returns at the following negedge
  task automatic step(vec_t t);
    res_t e;
    rst = t.rst;
    req0_valid = t.v0; req1_valid = t.v1;
    req0_a = t.a0; req0_b = t.b0; req0_f = t.f0;
    req1_a = t.a1; req1_b = t.b1; req1_f = t.f1;
    res_ready = t.rr;
    #1;
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, t.r0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, t.r1});
    if (t.r0) begin
      chk("add_a", add_a, t.a0);
      chk("add_b", add_b, t.b0);
      chk("add_f", {25'd0, add_f}, {25'd0, t.f0});
      sb.push_back(ref_add(1'b0, t.a0, t.b0, t.f0));
    end else if (t.r1) begin
      chk("add_a", add_a, t.a1);
      chk("add_b", add_b, t.b1);
      chk("add_f", {25'd0, add_f}, {25'd0, t.f1});
      sb.push_back(ref_add(1'b1, t.a1, t.b1, t.f1));
    end else begin
      chk("add_idle", {add_a ^ add_b, 25'd0, add_f} == '0 ? 32'd0 : 32'd1,
          32'd0);
    end
    @(posedge clk);
    #1;
    if (t.rst) begin
      exp_valid = 1'b0;
      exp_prio  = 1'b0;
      last      = '{id: 1'b0, y: 32'd0, c: 1'b0, v: 1'b0,
                    n: 1'b0, z: 1'b0};
    end else if (t.r0 || t.r1) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: got empty queue expected entry");
      end else begin
        e = sb.pop_front();
        last = e;
      end
      exp_valid = 1'b1;
      exp_prio  = t.r0;
    end else if (t.rr) begin
      exp_valid = 1'b0;
    end
    chk("res_valid", {31'd0, res_valid}, {31'd0, exp_valid});
    chk("res_id", {31'd0, res_id}, {31'd0, last.id});
    chk("res_y", res_y, last.y);
    chk("res_flags", {28'd0, res_c, res_v, res_n, res_z},
        {28'd0, last.c, last.v, last.n, last.z});
    @(negedge clk);
  endtask

  initial begin
    vec_t t;
    logic free;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_f = '0;
    req1_a = '0; req1_b = '0; req1_f = '0;
    res_ready = 1'b0;
    exp_valid = 1'b0;
    exp_prio  = 1'b0;
    last = '{id: 1'b0, y: 32'd0, c: 1'b0, v: 1'b0, n: 1'b0, z: 1'b0};

    // rst v0 v1 a0 b0 f0 a1 b1 f1 rr r0 r1
    tbl.push_back(mk(1, 1, 1, 1, 1, ADD, 2, 2, ADD, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 1, ADD, 2, 2, ADD, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 20, 22, ADD, 9, 4, SUB, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 5, 7, ADD, 0, 0, ADD, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, ADD, 3, 3, SUB, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, ADD, 32'h8000_0000, 1, SUB, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 10, 1, ADD, 100, 1, SUB, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 11, 1, ADD, 101, 1, SUB, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 12, 1, ADD, 102, 1, SUB, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 13, 1, ADD, 103, 1, SUB, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, ADD, 0, 0, ADD, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, ADD, 0, 0, ADD, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 2, ADD, 0, 0, ADD, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 4, 4, ADD, 0, 0, ADD, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4, 4, ADD, 0, 0, ADD, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4, 4, ADD, 0, 0, ADD, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4, 4, ADD, 0, 0, ADD, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 5, 7, ADD, 0, 0, ADD, 1, 1, 0));
    tbl.push_back(mk(1, 1, 1, 6, 6, ADD, 7, 7, ADD, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 6, 6, ADD, 7, 7, ADD, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 6, 6, ADD, 7, 7, ADD, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 6, 6, ADD, 7, 7, ADD, 1, 0, 1));

    @(negedge clk);
    foreach (tbl[i]) step(tbl[i]);

    // Random traffic with expected grants from a behavioural arbiter
    for (int i = 0; i < 60; i++) begin
      t = mk($urandom_range(0, 19) == 0, 1'($urandom), 1'($urandom),
             $urandom, $urandom, $urandom_range(0, 1) ? SUB : ADD,
             $urandom, $urandom, $urandom_range(0, 1) ? SUB : ADD,
             $urandom_range(0, 3) != 0, 1'b0, 1'b0);
      free = !exp_valid || t.rr;
      if (!t.rst && free) begin
        t.r0 = t.v0 && (!t.v1 || !exp_prio);
        t.r1 = t.v1 && !t.r0;
      end
      step(t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
